// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and constants for the TRNG arbiter
package trng_pkg;

  // Sequencer states: discard samples, serve requesters, or hold off after a bad stream
  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FAIL   = 2'd2
  } trng_state_e;

  localparam int TRNG_W            = 8;
  localparam int DEF_REP_LIMIT     = 4;
  localparam int DEF_WARMUP_CYCLES = 16;

  // Repetition counter width and its saturation value
  localparam int               REP_CNT_W   = 4;
  localparam logic [REP_CNT_W-1:0] REP_CNT_MAX = 4'd15;

  // Warm-up counter width; covers the full 1..255 parameter range
  localparam int WARM_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational masked-priority round-robin pick
module rr_arbiter #(
  parameter int N    = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] src;
  logic         found;

  // Prefer requesters at or above the pointer; fall back to the unmasked set to wrap around
  always_comb begin
    mask       = '0;
    masked_req = '0;
    src        = '0;
    gnt        = '0;
    idx        = '0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked_req = req & mask;
    src        = (|masked_req) ? masked_req : req;
    for (int i = 0; i < N; i++) begin
      if (src[i] && !found) begin
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/trng_arbiter.sv
// rtl/trng_arbiter.sv - TRNG stream sharing with warm-up, repetition health test and round-robin grants
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TRNG_W-1:0] rng_data,
  input  logic [NUM_REQ-1:0] req,
  input  logic              clear_fail,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TRNG_W-1:0] rand_data,
  output logic              busy_warmup,
  output logic              health_fail
);

  localparam int                      PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0]        PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [WARM_CNT_W-1:0]   WARM_LAST = WARM_CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [REP_CNT_W-1:0]    REP_LIM_C = REP_CNT_W'(REP_LIMIT);

  trng_state_e             state_q, state_d;
  logic [TRNG_W-1:0]       sample_q, sample_d;
  logic [TRNG_W-1:0]       prev_q, prev_d;
  logic                    sample_vld_q, sample_vld_d;
  logic                    prev_vld_q, prev_vld_d;
  logic [REP_CNT_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [WARM_CNT_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [TRNG_W-1:0]       rand_data_q, rand_data_d;

  logic [REP_CNT_W-1:0]    rep_next;
  logic                    limit_hit;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Two-deep sample pipeline; valid bits keep reset zeros from looking like a repeat
  always_comb begin
    sample_d     = rng_data;
    prev_d       = sample_q;
    sample_vld_d = 1'b1;
    prev_vld_d   = sample_vld_q;
  end

  // Repetition count for the sample currently held in sample_q
  always_comb begin
    rep_next = 4'd1;
    if (sample_vld_q && prev_vld_q && (sample_q == prev_q)) begin
      rep_next = (rep_cnt_q == REP_CNT_MAX) ? REP_CNT_MAX : rep_cnt_q + 4'd1;
    end
    limit_hit = (rep_next >= REP_LIM_C);
  end

  // Sequencer: warm-up counting, grant issue, fault entry and software clear
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    rep_cnt_d   = rep_next;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    rand_data_d = rand_data_q;
    case (state_q)
      WARMUP: begin
        if (limit_hit) begin
          state_d = FAIL;
        end else if (warm_cnt_q == WARM_LAST) begin
          state_d    = RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // A failing sample is never handed out
        if (limit_hit) begin
          state_d = FAIL;
        end else if (arb_any) begin
          gnt_d       = arb_gnt;
          rand_data_d = sample_q;
          rr_ptr_d    = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
        end
      end
      FAIL: begin
        if (clear_fail) begin
          state_d    = WARMUP;
          warm_cnt_d = '0;
          rep_cnt_d  = 4'd1;
        end
      end
      default: begin
        state_d = WARMUP;
      end
    endcase
  end

  // State and output registers; reset drops any grant in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WARMUP;
      sample_q     <= '0;
      prev_q       <= '0;
      sample_vld_q <= 1'b0;
      prev_vld_q   <= 1'b0;
      rep_cnt_q    <= 4'd1;
      warm_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      rand_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      prev_q       <= prev_d;
      sample_vld_q <= sample_vld_d;
      prev_vld_q   <= prev_vld_d;
      rep_cnt_q    <= rep_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      rand_data_q  <= rand_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rand_data   = rand_data_q;
  assign busy_warmup = (state_q == WARMUP);
  assign health_fail = (state_q == FAIL);

endmodule

// File: tb/tb_trng_arbiter.sv
// tb/tb_trng_arbiter.sv - self-checking bench for trng_arbiter
module tb_trng_arbiter;

  localparam int N  = 4;
  localparam int WC = 16;
  localparam int RL = 4;

  localparam int M_WARM = 0;
  localparam int M_RUN  = 1;
  localparam int M_FAIL = 2;

  logic         clk;
  logic         reset_n;
  logic [7:0]   rng_data;
  logic [N-1:0] req;
  logic         clear_fail;
  logic [N-1:0] gnt;
  logic [7:0]   rand_data;
  logic         busy_warmup;
  logic         health_fail;

  int total;
  int bad;

  // Reference model: history of registered samples plus sequencer mode
  logic [7:0]   hist[$];
  int           base;
  int           m_state;
  int           m_warm;
  int           m_ptr;
  logic [N-1:0] m_gnt;
  logic [7:0]   m_rd;

  trng_arbiter #(
    .NUM_REQ       (N),
    .WARMUP_CYCLES (WC),
    .REP_LIMIT     (RL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rng_data    (rng_data),
    .req         (req),
    .clear_fail  (clear_fail),
    .gnt         (gnt),
    .rand_data   (rand_data),
    .busy_warmup (busy_warmup),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    base    = 0;
    m_state = M_WARM;
    m_warm  = 0;
    m_ptr   = 0;
    m_gnt   = '0;
    m_rd    = 8'h00;
  endtask

  // Length of the trailing run of identical samples since the last boundary
  function automatic int run_len();
    int n;
    n = 1;
    if (hist.size() == 0) return 1;
    for (int k = hist.size() - 1; k > base; k--) begin
      if (n >= 15) break;
      if (hist[k] == hist[k-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step();
    logic [7:0] cur;
    bit         hit;
    bit         found;
    int         i;
    cur   = (hist.size() == 0) ? 8'h00 : hist[hist.size()-1];
    hit   = (run_len() >= RL);
    m_gnt = '0;
    found = 1'b0;
    if (m_state == M_WARM) begin
      if (hit) m_state = M_FAIL;
      else begin
        m_warm++;
        if (m_warm == WC) m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (hit) m_state = M_FAIL;
      else begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (!found && req[i]) begin
            found    = 1'b1;
            m_gnt[i] = 1'b1;
            m_rd     = cur;
            m_ptr    = (i + 1) % N;
          end
        end
      end
    end else begin
      if (clear_fail) begin
        m_state = M_WARM;
        m_warm  = 0;
        base    = (hist.size() > 0) ? hist.size() - 1 : 0;
      end
    end
    hist.push_back(rng_data);
  endtask

  task automatic check_outputs();
    chk("gnt", {28'b0, gnt}, {28'b0, m_gnt});
    chk("rand_data", {24'b0, rand_data}, {24'b0, m_rd});
    chk("busy_warmup", {31'b0, busy_warmup}, {31'b0, (m_state == M_WARM)});
    chk("health_fail", {31'b0, health_fail}, {31'b0, (m_state == M_FAIL)});
    chk("onehot", {31'b0, ($countones(gnt) <= 1)}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  function automatic logic [7:0] clean_byte(input logic [7:0] p);
    logic [7:0] v;
    v = 8'($urandom);
    if (v == p) v = p ^ 8'h5A;
    return v;
  endfunction

  function automatic logic [7:0] sticky_byte(input logic [7:0] p);
    if ($urandom_range(0, 1) == 1) return p;
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0]   drv[0:31];
    logic [3:0]   fair_exp[0:4];
    int           busy_cnt;
    int           first_cyc;
    logic [7:0]   first_rd;
    logic [N-1:0] first_g;
    logic [N-1:0] last_g;
    int           seen;
    int           bad_hold;
    int           found;

    total = 0;
    bad   = 0;
    fair_exp[0] = 4'b0010; fair_exp[1] = 4'b0100; fair_exp[2] = 4'b1000;
    fair_exp[3] = 4'b0001; fair_exp[4] = 4'b0010;

    // Reset state
    reset_n    = 1'b0;
    req        = '0;
    clear_fail = 1'b0;
    rng_data   = 8'h3C;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_rand_data", {24'b0, rand_data}, 32'h0);
    reset_n = 1'b1;

    // Warm-up then first grant to requester 0
    req      = 4'b0001;
    busy_cnt = busy_warmup ? 1 : 0;
    first_cyc = -1;
    first_rd  = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      drv[k-1] = rng_data;
      tick();
      if (busy_warmup) busy_cnt++;
      if (gnt != 0 && first_cyc < 0) begin
        first_cyc = k;
        first_rd  = rand_data;
        first_g   = gnt;
      end
      rng_data = clean_byte(rng_data);
    end
    chk("warmup_len", busy_cnt, WC);
    chk("first_gnt_cycle", first_cyc, WC + 1);
    chk("first_gnt_val", {28'b0, first_g}, 32'b0001);
    chk("first_rand_data", {24'b0, first_rd}, {24'b0, drv[WC-1]});

    // Round-robin fairness under full contention
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_seq", {28'b0, gnt}, {28'b0, fair_exp[k]});
      rng_data = clean_byte(rng_data);
    end

    // Sparse request set and pointer wrap
    req = 4'b1000;
    tick();
    chk("wrap_g3", {28'b0, gnt}, 32'b1000);
    rng_data = clean_byte(rng_data);
    req = 4'b1001;
    tick();
    chk("wrap_g0", {28'b0, gnt}, 32'b0001);
    rng_data = clean_byte(rng_data);
    tick();
    chk("wrap_g3b", {28'b0, gnt}, 32'b1000);

    // Health failure on a stuck stream
    req      = 4'b1111;
    rng_data = 8'hA5;
    seen     = 0;
    last_g   = '0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      last_g = gnt;
      tick();
      if (health_fail) seen = 1;
    end
    chk("fail_seen", seen, 1);
    chk("fail_cycle_gnt", {28'b0, gnt}, 32'b0);
    chk("pre_fail_gnt", {31'b0, (last_g != 0)}, 32'd1);
    bad_hold = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!health_fail || gnt != 0) bad_hold++;
    end
    chk("fail_hold", bad_hold, 0);

    // Fault clear and re-warm-up
    for (int k = 0; k < 3; k++) begin
      rng_data = clean_byte(rng_data);
      tick();
    end
    rng_data   = clean_byte(rng_data);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("clear_health", {31'b0, health_fail}, 32'd0);
    chk("clear_busy", {31'b0, busy_warmup}, 32'd1);
    busy_cnt  = 1;
    first_cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      rng_data = clean_byte(rng_data);
      tick();
      if (busy_warmup) busy_cnt++;
      if (gnt != 0 && first_cyc < 0) first_cyc = k;
    end
    chk("rewarm_len", busy_cnt, WC);
    chk("rewarm_first_gnt", first_cyc, WC + 1);

    // clear_fail in RUN is ignored
    rng_data   = clean_byte(rng_data);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("clr_run_busy", {31'b0, busy_warmup}, 32'd0);
    rng_data = clean_byte(rng_data);
    tick();
    chk("clr_run_gnt", {31'b0, (gnt != 0)}, 32'd1);

    // Randomized traffic, sticky data and random clears
    for (int k = 0; k < 400; k++) begin
      req        = 4'($urandom_range(0, 15));
      rng_data   = sticky_byte(rng_data);
      clear_fail = ($urandom_range(0, 9) == 0);
      tick();
    end
    clear_fail = 1'b0;

    // Asynchronous reset while requester 2 holds a grant
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    req     = 4'b0100;
    found   = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      rng_data = clean_byte(rng_data);
      tick();
      if (gnt == 4'b0100) found = 1;
    end
    chk("g2_reached", found, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_gnt", {28'b0, gnt}, 32'b0);
    chk("async_busy", {31'b0, busy_warmup}, 32'd1);
    chk("async_health", {31'b0, health_fail}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    req       = 4'b1111;
    first_cyc = -1;
    first_g   = '0;
    for (int k = 1; k <= 20; k++) begin
      rng_data = clean_byte(rng_data);
      tick();
      if (gnt != 0 && first_cyc < 0) begin
        first_cyc = k;
        first_g   = gnt;
      end
    end
    chk("post_reset_first_cyc", first_cyc, WC + 1);
    chk("post_reset_ptr0", {28'b0, first_g}, 32'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
